// File: rtl/axil_buffer_if.sv
// AxiLite: AXI-Lite interface bundle shared by the upstream (S) and
// downstream (M) sides of axil_buffer.
//   Parameters: ADDR_W (address width), DATA_W (data width, strobe = DATA_W/8)
//   Signals   : aclk/aresetn (carried for completeness), AW, W, B, AR, R channels
//   Modports  : S (slave view), M (master view)
interface AxiLite #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                aclk;
    logic                aresetn;
    logic                awValid;
    logic                awReady;
    logic [ADDR_W-1:0]   awAddr;
    logic [2:0]          awProt;
    logic                wValid;
    logic                wReady;
    logic [DATA_W-1:0]   wData;
    logic [DATA_W/8-1:0] wStrb;
    logic                bValid;
    logic                bReady;
    logic [1:0]          bResp;
    logic                arValid;
    logic                arReady;
    logic [ADDR_W-1:0]   arAddr;
    logic [2:0]          arProt;
    logic                rValid;
    logic                rReady;
    logic [DATA_W-1:0]   rData;
    logic [1:0]          rResp;

    modport S (
        input  aclk, aresetn,
        input  awValid, awAddr, awProt, output awReady,
        input  wValid, wData, wStrb,    output wReady,
        output bValid, bResp,           input  bReady,
        input  arValid, arAddr, arProt, output arReady,
        output rValid, rData, rResp,    input  rReady
    );

    modport M (
        input  aclk, aresetn,
        output awValid, awAddr, awProt, input  awReady,
        output wValid, wData, wStrb,    input  wReady,
        input  bValid, bResp,           output bReady,
        output arValid, arAddr, arProt, input  arReady,
        input  rValid, rData, rResp,    output rReady
    );
endinterface

// File: rtl/axil_buffer.sv
// axil_buffer: parametrised AXI-Lite pipeline buffer with a per-channel
// elastic stage (wire / half-rate register / skid / FIFO) and a per-direction
// outstanding-transaction limiter.
//   clk            system clock (si.aclk / mi.aclk unused)
//   rstn           asynchronous active-low reset (si.aresetn unused)
//   si             upstream AxiLite.S port
//   mi             downstream AxiLite.M port
//   wrOutstanding  accepted writes not yet answered on si B
//   rdOutstanding  accepted reads not yet answered on si R
//   idle           all stages empty and both counts zero
// Optional: define AXIL_BUFFER_STATS_EN to add wrCount, rdCount, errCount.

// axil_buffer_stage: one valid/ready elastic stage.
//   DEPTH 0 wire, 1 single register, 2 skid buffer, >2 circular FIFO.
//   empty_o is high when no beat is held.
module axil_buffer_stage #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic         empty_o
);
    if (DEPTH <= 0) begin : g_wire
        // en_q keeps ready/valid low during reset and releases on the first edge.
        logic en_q;
        always_ff @(posedge clk or negedge rstn)
            if (!rstn) en_q <= 1'b0;
            else       en_q <= 1'b1;
        assign out_valid_o = in_valid_i & en_q;
        assign in_ready_o  = out_ready_i & en_q;
        assign out_data_o  = in_data_i;
        assign empty_o     = 1'b1;
    end else if (DEPTH == 1) begin : g_reg
        logic         en_q, valid_q;
        logic [W-1:0] data_q;
        // Accepting only when empty gives one beat every two cycles.
        assign in_ready_o  = en_q & ~valid_q;
        assign out_valid_o = valid_q;
        assign out_data_o  = data_q;
        assign empty_o     = ~valid_q;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                en_q    <= 1'b0;
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                en_q <= 1'b1;
                if (in_valid_i && in_ready_o) begin
                    valid_q <= 1'b1;
                    data_q  <= in_data_i;
                end else if (out_ready_i) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end else if (DEPTH == 2) begin : g_skid
        logic         valid_q, valid_d, skid_q, skid_d, ready_q;
        logic [W-1:0] data_q, data_d, skid_data_q, skid_data_d;
        logic         push, pop;
        assign push        = in_valid_i & ready_q;
        assign pop         = valid_q & out_ready_i;
        assign in_ready_o  = ready_q;
        assign out_valid_o = valid_q;
        assign out_data_o  = data_q;
        assign empty_o     = ~valid_q & ~skid_q;
        always_comb begin
            valid_d     = valid_q;
            data_d      = data_q;
            skid_d      = skid_q;
            skid_data_d = skid_data_q;
            if (skid_q) begin
                if (pop) begin
                    data_d = skid_data_q;
                    skid_d = 1'b0;
                end
            end else if (push) begin
                if (!valid_q || pop) begin
                    valid_d = 1'b1;
                    data_d  = in_data_i;
                end else begin
                    skid_d      = 1'b1;
                    skid_data_d = in_data_i;
                end
            end else if (pop) begin
                valid_d = 1'b0;
            end
        end
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                valid_q     <= 1'b0;
                skid_q      <= 1'b0;
                ready_q     <= 1'b0;
                data_q      <= '0;
                skid_data_q <= '0;
            end else begin
                valid_q     <= valid_d;
                skid_q      <= skid_d;
                data_q      <= data_d;
                skid_data_q <= skid_data_d;
                // Ready comes from a flop so no combinational ready path crosses the stage.
                ready_q     <= ~skid_d;
            end
        end
    end else begin : g_fifo
        localparam int PW = $clog2(DEPTH);
        localparam int CW = $clog2(DEPTH + 1);
        logic          en_q;
        logic [W-1:0]  mem_q [DEPTH];
        logic [PW-1:0] wr_ptr_q, rd_ptr_q;
        logic [CW-1:0] cnt_q;
        logic          push, pop;
        assign in_ready_o  = en_q & (cnt_q != CW'(DEPTH));
        assign out_valid_o = (cnt_q != '0);
        assign out_data_o  = mem_q[rd_ptr_q];
        assign empty_o     = (cnt_q == '0);
        assign push        = in_valid_i & in_ready_o;
        assign pop         = out_valid_o & out_ready_i;
        always_ff @(posedge clk)
            if (push) mem_q[wr_ptr_q] <= in_data_i;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                en_q     <= 1'b0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                en_q <= 1'b1;
                if (push) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
                if (push && !pop)      cnt_q <= cnt_q + 1'b1;
                else if (pop && !push) cnt_q <= cnt_q - 1'b1;
            end
        end
    end
endmodule

module axil_buffer #(
    parameter int DATA_W   = 32,
    parameter int AW_DEPTH = 2,
    parameter int W_DEPTH  = 2,
    parameter int B_DEPTH  = 2,
    parameter int AR_DEPTH = 2,
    parameter int R_DEPTH  = 2,
    parameter int MAX_OUT  = 4,
    localparam int CNT_W   = (MAX_OUT > 0) ? $clog2(MAX_OUT + 1) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    AxiLite.S                si,
    AxiLite.M                mi,
    output logic [CNT_W-1:0] wrOutstanding,
    output logic [CNT_W-1:0] rdOutstanding,
    output logic             idle
`ifdef AXIL_BUFFER_STATS_EN
    ,
    output logic [31:0]      wrCount,
    output logic [31:0]      rdCount,
    output logic [15:0]      errCount
`endif
);
    localparam int ADDR_W = $bits(si.awAddr);
    localparam int AW_W   = ADDR_W + 3;
    localparam int W_W    = DATA_W / 8 + DATA_W;
    localparam int R_W    = DATA_W + 2;

    if ($bits(si.awAddr) != $bits(mi.awAddr)) begin : g_chk_addr
        $error("axil_buffer: si/mi ADDR_W mismatch");
    end
    if ($bits(si.wData) != $bits(mi.wData) || $bits(si.wData) != DATA_W) begin : g_chk_data
        $error("axil_buffer: si/mi DATA_W mismatch");
    end
    if (DATA_W != 32 && DATA_W != 64) begin : g_chk_dw
        $error("axil_buffer: DATA_W must be 32 or 64");
    end
    if (AW_DEPTH < 0 || W_DEPTH < 0 || B_DEPTH < 0 || AR_DEPTH < 0 || R_DEPTH < 0) begin : g_chk_depth
        $error("axil_buffer: negative channel depth");
    end

    logic             wr_full, rd_full, aw_in_ready, ar_in_ready;
    logic             aw_empty, w_empty, b_empty, ar_empty, r_empty;
    logic             aw_hs, b_hs, ar_hs, r_hs;
    logic [AW_W-1:0]  aw_data, ar_data;
    logic [W_W-1:0]   w_data;
    logic [R_W-1:0]   r_data;
    logic [1:0]       b_data;
    logic [CNT_W-1:0] wr_out_q, wr_out_d, rd_out_q, rd_out_d;

    // Limiter: at the cap, ready is forced low and the stage input masked.
    assign wr_full    = (MAX_OUT > 0) && (wr_out_q == CNT_W'(MAX_OUT));
    assign rd_full    = (MAX_OUT > 0) && (rd_out_q == CNT_W'(MAX_OUT));
    assign si.awReady = aw_in_ready & ~wr_full;
    assign si.arReady = ar_in_ready & ~rd_full;
    assign aw_hs      = si.awValid & si.awReady;
    assign ar_hs      = si.arValid & si.arReady;
    assign b_hs       = si.bValid & si.bReady;
    assign r_hs       = si.rValid & si.rReady;

    axil_buffer_stage #(.DEPTH(AW_DEPTH), .W(AW_W)) u_aw (
        .clk, .rstn,
        .in_valid_i (si.awValid & ~wr_full), .in_ready_o (aw_in_ready),
        .in_data_i  ({si.awProt, si.awAddr}),
        .out_valid_o(mi.awValid), .out_ready_i(mi.awReady), .out_data_o(aw_data),
        .empty_o    (aw_empty));
    assign {mi.awProt, mi.awAddr} = aw_data;

    axil_buffer_stage #(.DEPTH(W_DEPTH), .W(W_W)) u_w (
        .clk, .rstn,
        .in_valid_i (si.wValid), .in_ready_o (si.wReady), .in_data_i({si.wStrb, si.wData}),
        .out_valid_o(mi.wValid), .out_ready_i(mi.wReady), .out_data_o(w_data),
        .empty_o    (w_empty));
    assign {mi.wStrb, mi.wData} = w_data;

    axil_buffer_stage #(.DEPTH(B_DEPTH), .W(2)) u_b (
        .clk, .rstn,
        .in_valid_i (mi.bValid), .in_ready_o (mi.bReady), .in_data_i(mi.bResp),
        .out_valid_o(si.bValid), .out_ready_i(si.bReady), .out_data_o(b_data),
        .empty_o    (b_empty));
    assign si.bResp = b_data;

    axil_buffer_stage #(.DEPTH(AR_DEPTH), .W(AW_W)) u_ar (
        .clk, .rstn,
        .in_valid_i (si.arValid & ~rd_full), .in_ready_o (ar_in_ready),
        .in_data_i  ({si.arProt, si.arAddr}),
        .out_valid_o(mi.arValid), .out_ready_i(mi.arReady), .out_data_o(ar_data),
        .empty_o    (ar_empty));
    assign {mi.arProt, mi.arAddr} = ar_data;

    axil_buffer_stage #(.DEPTH(R_DEPTH), .W(R_W)) u_r (
        .clk, .rstn,
        .in_valid_i (mi.rValid), .in_ready_o (mi.rReady), .in_data_i({mi.rResp, mi.rData}),
        .out_valid_o(si.rValid), .out_ready_i(si.rReady), .out_data_o(r_data),
        .empty_o    (r_empty));
    assign {si.rResp, si.rData} = r_data;

    // Saturates at all-ones (only reachable when unlimited); a response with
    // nothing outstanding is a protocol error and leaves the count at 0.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic dec);
        if (inc && !dec) return (c == '1) ? c : c + 1'b1;
        if (dec && !inc) return (c == '0) ? c : c - 1'b1;
        return c;
    endfunction

    assign wr_out_d = cnt_next(wr_out_q, aw_hs, b_hs);
    assign rd_out_d = cnt_next(rd_out_q, ar_hs, r_hs);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_out_q <= '0;
            rd_out_q <= '0;
        end else begin
            wr_out_q <= wr_out_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign wrOutstanding = wr_out_q;
    assign rdOutstanding = rd_out_q;
    assign idle = aw_empty & w_empty & b_empty & ar_empty & r_empty
                & (wr_out_q == '0) & (rd_out_q == '0);

`ifdef AXIL_BUFFER_STATS_EN
    logic [31:0] wr_cnt_q, rd_cnt_q;
    logic [15:0] err_cnt_q;
    logic [16:0] err_sum;
    logic [1:0]  err_inc;
    // B and R errors can land in the same cycle, so the error count may step by 2.
    assign err_inc = 2'(b_hs && si.bResp != 2'b00) + 2'(r_hs && si.rResp != 2'b00);
    assign err_sum = {1'b0, err_cnt_q} + 17'(err_inc);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            if (b_hs && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 1'b1;
            if (r_hs && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 1'b1;
            err_cnt_q <= err_sum[16] ? '1 : err_sum[15:0];
        end
    end
    assign wrCount  = wr_cnt_q;
    assign rdCount  = rd_cnt_q;
    assign errCount = err_cnt_q;
`endif
endmodule

// File: tb/tb_axil_buffer.sv
// tb_axil_buffer: directed bench for axil_buffer. Three instances cover the
// different depth / limiter configurations:
//   u_a: all depths 2, MAX_OUT=0
//   u_b: AW=1, W=0, B=2, AR=3 (FIFO), R=4 (FIFO), MAX_OUT=8
//   u_c: AW=0, W=2, B=0, AR=1, R=0, MAX_OUT=2
// Inputs are driven at the falling edge, outputs sampled 1ns later.
module tb_axil_buffer;
    logic clk = 1'b0;
    logic rstn_a, rstn_b, rstn_c;
    always #5 clk = ~clk;

    AxiLite #(.ADDR_W(32), .DATA_W(32)) si_a (), mi_a (), si_b (), mi_b (), si_c (), mi_c ();

    logic [0:0] wro_a, rdo_a;
    logic [3:0] wro_b, rdo_b;
    logic [1:0] wro_c, rdo_c;
    logic       idle_a, idle_b, idle_c;
`ifdef AXIL_BUFFER_STATS_EN
    logic [31:0] wrc_a, rdc_a, wrc_b, rdc_b, wrc_c, rdc_c;
    logic [15:0] errc_a, errc_b, errc_c;
`endif

    axil_buffer #(.DATA_W(32), .AW_DEPTH(2), .W_DEPTH(2), .B_DEPTH(2), .AR_DEPTH(2),
                  .R_DEPTH(2), .MAX_OUT(0)) u_a (
        .clk(clk), .rstn(rstn_a), .si(si_a), .mi(mi_a),
        .wrOutstanding(wro_a), .rdOutstanding(rdo_a), .idle(idle_a)
`ifdef AXIL_BUFFER_STATS_EN
        , .wrCount(wrc_a), .rdCount(rdc_a), .errCount(errc_a)
`endif
    );

    axil_buffer #(.DATA_W(32), .AW_DEPTH(1), .W_DEPTH(0), .B_DEPTH(2), .AR_DEPTH(3),
                  .R_DEPTH(4), .MAX_OUT(8)) u_b (
        .clk(clk), .rstn(rstn_b), .si(si_b), .mi(mi_b),
        .wrOutstanding(wro_b), .rdOutstanding(rdo_b), .idle(idle_b)
`ifdef AXIL_BUFFER_STATS_EN
        , .wrCount(wrc_b), .rdCount(rdc_b), .errCount(errc_b)
`endif
    );

    axil_buffer #(.DATA_W(32), .AW_DEPTH(0), .W_DEPTH(2), .B_DEPTH(0), .AR_DEPTH(1),
                  .R_DEPTH(0), .MAX_OUT(2)) u_c (
        .clk(clk), .rstn(rstn_c), .si(si_c), .mi(mi_c),
        .wrOutstanding(wro_c), .rdOutstanding(rdo_c), .idle(idle_c)
`ifdef AXIL_BUFFER_STATS_EN
        , .wrCount(wrc_c), .rdCount(rdc_c), .errCount(errc_c)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [1:0] pat [5];
    logic [3:0] st  [3];
    logic [3:0] rdy_exp;
    int sent, got, k;

    initial begin
        pat = '{2'd0, 2'd2, 2'd0, 2'd3, 2'd0};
        st  = '{4'hF, 4'h3, 4'h8};
        rdy_exp = 4'b0011;
        rstn_a = 1'b0; rstn_b = 1'b0; rstn_c = 1'b0;
        si_a.awValid = 0; si_a.awAddr = 0; si_a.awProt = 0; si_a.wValid = 0; si_a.wData = 0;
        si_a.wStrb = 0; si_a.bReady = 0; si_a.arValid = 0; si_a.arAddr = 0; si_a.arProt = 0;
        si_a.rReady = 0;
        si_b.awValid = 0; si_b.awAddr = 0; si_b.awProt = 0; si_b.wValid = 0; si_b.wData = 0;
        si_b.wStrb = 0; si_b.bReady = 0; si_b.arValid = 0; si_b.arAddr = 0; si_b.arProt = 0;
        si_b.rReady = 0;
        si_c.awValid = 0; si_c.awAddr = 0; si_c.awProt = 0; si_c.wValid = 0; si_c.wData = 0;
        si_c.wStrb = 0; si_c.bReady = 0; si_c.arValid = 0; si_c.arAddr = 0; si_c.arProt = 0;
        si_c.rReady = 0;
        mi_a.awReady = 1; mi_a.wReady = 1; mi_a.bValid = 0; mi_a.bResp = 0; mi_a.arReady = 1;
        mi_a.rValid = 0; mi_a.rData = 0; mi_a.rResp = 0;
        mi_b.awReady = 1; mi_b.wReady = 1; mi_b.bValid = 0; mi_b.bResp = 0; mi_b.arReady = 1;
        mi_b.rValid = 0; mi_b.rData = 0; mi_b.rResp = 0;
        mi_c.awReady = 1; mi_c.wReady = 1; mi_c.bValid = 0; mi_c.bResp = 0; mi_c.arReady = 1;
        mi_c.rValid = 0; mi_c.rData = 0; mi_c.rResp = 0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_a_awvalid", mi_a.awValid, 0);
        chk("rst_a_awready", si_a.awReady, 0);
        chk("rst_a_idle", idle_a, 1);
        chk("rst_b_rvalid", si_b.rValid, 0);
        chk("rst_b_arready", si_b.arReady, 0);
        chk("rst_b_wrout", wro_b, 0);
        chk("rst_c_awready", si_c.awReady, 0);
        @(negedge clk);
        rstn_a = 1'b1; rstn_b = 1'b1; rstn_c = 1'b1;
        #1;
        chk("rel_a_awready", si_a.awReady, 0);
        chk("rel_c_awready", si_c.awReady, 0);

        // T1: 16 back-to-back writes through a skid AW stage
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
            @(negedge clk);
            si_a.awValid = (sent < 16);
            si_a.awAddr  = 32'(sent * 4);
            si_a.awProt  = 3'd2;
            #1;
            if (mi_a.awValid) begin
                chk("t1_addr", mi_a.awAddr, 64'(got * 4));
                chk("t1_prot", mi_a.awProt, 2);
                chk("t1_cycle", 64'(cyc), 64'(got + 1));
                got++;
            end
            if (si_a.awValid) begin
                chk("t1_awready", si_a.awReady, 1);
                if (si_a.awReady) sent++;
            end
        end
        @(negedge clk);
        si_a.awValid = 0;
        #1;
        chk("t1_beats", 64'(got), 16);
        chk("t1_wrout_sat", wro_a, 1);
        chk("t1_idle", idle_a, 0);

        // T6: B responses with nothing outstanding (counter holds at 0) and stats
        @(negedge clk);
        rstn_a = 1'b0;
        #1;
        chk("t6_rst_idle", idle_a, 1);
        chk("t6_rst_wrout", wro_a, 0);
        @(negedge clk);
        rstn_a = 1'b1;
        si_a.bReady = 1;
        k = 0; got = 0;
        for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
            @(negedge clk);
            mi_a.bValid = (k < 5);
            if (k < 5) mi_a.bResp = pat[k];
            #1;
            if (si_a.bValid) begin
                chk("t6_bresp", si_a.bResp, pat[got]);
                got++;
            end
            if (mi_a.bValid && mi_a.bReady) k++;
            chk("t6_wrout_hold0", wro_a, 0);
        end
        @(negedge clk);
        mi_a.bValid = 0;
        #1;
        chk("t6_beats", 64'(got), 5);
`ifdef AXIL_BUFFER_STATS_EN
        chk("t6_wrcount", wrc_a, 5);
        chk("t6_errcount", errc_a, 2);
        chk("t6_rdcount", rdc_a, 0);
`endif

        // T2: AW_DEPTH=1 half-rate, then MAX_OUT=8 cap
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 17; cyc++) begin
            @(negedge clk);
            si_b.awValid = 1;
            si_b.awAddr  = 32'h100 + 32'(sent * 4);
            #1;
            chk("t2_awready", si_b.awReady, (cyc < 16 && cyc % 2 == 0));
            if (si_b.awReady) sent++;
            if (mi_b.awValid) begin
                chk("t2_addr", mi_b.awAddr, 64'(32'h100 + got * 4));
                got++;
            end
        end
        @(negedge clk);
        si_b.awValid = 0;
        #1;
        chk("t2_sent", 64'(sent), 8);
        chk("t2_mi_beats", 64'(got), 8);
        chk("t2_wrout_cap", wro_b, 8);

        // T3: 6 reads, R FIFO of 4 with si rReady low, then release
        sent = 0;
        for (int cyc = 0; cyc < 12 && sent < 6; cyc++) begin
            @(negedge clk);
            si_b.arValid = 1;
            si_b.arAddr  = 32'h300 + 32'(sent * 4);
            #1;
            if (si_b.arReady) sent++;
        end
        @(negedge clk);
        si_b.arValid = 0;
        #1;
        chk("t3_sent", 64'(sent), 6);
        chk("t3_rdout", rdo_b, 6);
        k = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            mi_b.rValid = (k < 6);
            mi_b.rData  = 32'hA0 + 32'(k);
            #1;
            if (mi_b.rValid && mi_b.rReady) k++;
        end
        chk("t3_stored", 64'(k), 4);
        chk("t3_mi_rready", mi_b.rReady, 0);
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 6; cyc++) begin
            @(negedge clk);
            si_b.rReady = 1;
            mi_b.rValid = (k < 6);
            mi_b.rData  = 32'hA0 + 32'(k);
            #1;
            if (si_b.rValid) begin
                chk("t3_rdata", si_b.rData, 64'(32'hA0 + got));
                got++;
            end
            if (mi_b.rValid && mi_b.rReady) k++;
        end
        @(negedge clk);
        mi_b.rValid = 0;
        si_b.rReady = 0;
        #1;
        chk("t3_beats", 64'(got), 6);
        chk("t3_rdout_end", rdo_b, 0);

        // T5: fill AR FIFO (3) with mi stalled, then asynchronous reset
        mi_b.arReady = 0;
        sent = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            si_b.arValid = 1;
            si_b.arAddr  = 32'h400 + 32'(sent * 4);
            #1;
            if (si_b.arReady) sent++;
        end
        chk("t5_sent", 64'(sent), 3);
        chk("t5_full_ready", si_b.arReady, 0);
        chk("t5_mi_arvalid", mi_b.arValid, 1);
        chk("t5_mi_araddr", mi_b.arAddr, 32'h400);
        chk("t5_rdout", rdo_b, 3);
        rstn_b = 1'b0;
        si_b.arValid = 0;
        #1;
        chk("t5_rst_arvalid", mi_b.arValid, 0);
        chk("t5_rst_idle", idle_b, 1);
        chk("t5_rst_rdout", rdo_b, 0);
        chk("t5_rst_arready", si_b.arReady, 0);
        @(negedge clk);
        rstn_b = 1'b1;
        mi_b.arReady = 1;
        #1;
        chk("t5_rel_arready", si_b.arReady, 0);
        @(negedge clk);
        #1;
        chk("t5_up_arready", si_b.arReady, 1);
        chk("t5_up_idle", idle_b, 1);
        chk("t5_up_arvalid", mi_b.arValid, 0);
        chk("t5_up_wrout", wro_b, 0);

        // T4a: W skid stage carries data and strobe in order
        k = 0; got = 0;
        for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
            @(negedge clk);
            si_c.wValid = (k < 3);
            si_c.wData  = 32'h1111_0000 + 32'(k);
            if (k < 3) si_c.wStrb = st[k];
            #1;
            if (mi_c.wValid) begin
                chk("t4_wdata", mi_c.wData, 64'(32'h1111_0000 + got));
                chk("t4_wstrb", mi_c.wStrb, st[got]);
                got++;
            end
            if (si_c.wValid && si_c.wReady) k++;
        end
        @(negedge clk);
        si_c.wValid = 0;
        #1;
        chk("t4_wbeats", 64'(got), 3);

        // T4b: MAX_OUT=2 limiter with wire AW and B
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            si_c.awValid = 1;
            si_c.awAddr  = 32'h500 + 32'(cyc * 4);
            #1;
            chk("t4_awready", si_c.awReady, rdy_exp[cyc]);
        end
        chk("t4_wrout_cap", wro_c, 2);
        chk("t4_mask_awvalid", mi_c.awValid, 0);
        @(negedge clk);
        si_c.awValid = 0;
        mi_c.bValid  = 1;
        mi_c.bResp   = 0;
        si_c.bReady  = 1;
        #1;
        chk("t4_si_bvalid", si_c.bValid, 1);
        chk("t4_mi_bready", mi_c.bReady, 1);
        @(negedge clk);
        si_c.awValid = 1;
        mi_c.bValid  = 1;
        #1;
        chk("t4_wrout_after_b", wro_c, 1);
        chk("t4_awready_after_b", si_c.awReady, 1);
        @(negedge clk);
        si_c.awValid = 0;
        mi_c.bValid  = 0;
        #1;
        chk("t4_wrout_incdec", wro_c, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
